// File: rtl/mci_cif_req_arb.sv
// -----------------------------------------------------------------------------
// mci_cif_req_arb
//
// Serializes merged AXI write requests (AW+W) and read requests (AR) onto a
// single cif-style request channel feeding the MCI address decoder. Exactly
// one transaction is in flight at a time: grant, hold the request until the
// decoder drops cif_hold, then present the completion on the originating
// response channel until it is consumed. Contested grants alternate between
// the read and write channels, starting with the write channel after reset.
//
// Ports
//   clk, rst_b                       clock, asynchronous active-low reset
//   wr_req_valid / wr_req_ready      write request handshake (ready is a
//                                    same-cycle grant strobe)
//   wr_req_addr/wdata/wstrb/user/id  write payload
//   rd_req_valid / rd_req_ready      read request handshake
//   rd_req_addr/user/id              read payload
//   wr_resp_valid/ready/error/id     write completion
//   rd_resp_valid/ready/error/rdata/id  read completion
//   cif_dv, cif_write, cif_addr, cif_wdata, cif_wstrb, cif_user, cif_id
//                                    registered request to the decoder
//   cif_hold, cif_rdata, cif_error   decoder stall, read data, error
// -----------------------------------------------------------------------------
module mci_cif_req_arb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 32,
   parameter int ID_WIDTH   = 8
) (
   input  logic                    clk,
   input  logic                    rst_b,

   input  logic                    wr_req_valid,
   output logic                    wr_req_ready,
   input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
   input  logic [DATA_WIDTH-1:0]   wr_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] wr_req_wstrb,
   input  logic [USER_WIDTH-1:0]   wr_req_user,
   input  logic [ID_WIDTH-1:0]     wr_req_id,

   input  logic                    rd_req_valid,
   output logic                    rd_req_ready,
   input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
   input  logic [USER_WIDTH-1:0]   rd_req_user,
   input  logic [ID_WIDTH-1:0]     rd_req_id,

   output logic                    wr_resp_valid,
   input  logic                    wr_resp_ready,
   output logic                    wr_resp_error,
   output logic [ID_WIDTH-1:0]     wr_resp_id,

   output logic                    rd_resp_valid,
   input  logic                    rd_resp_ready,
   output logic                    rd_resp_error,
   output logic [DATA_WIDTH-1:0]   rd_resp_rdata,
   output logic [ID_WIDTH-1:0]     rd_resp_id,

   output logic                    cif_dv,
   output logic                    cif_write,
   output logic [ADDR_WIDTH-1:0]   cif_addr,
   output logic [DATA_WIDTH-1:0]   cif_wdata,
   output logic [DATA_WIDTH/8-1:0] cif_wstrb,
   output logic [USER_WIDTH-1:0]   cif_user,
   output logic [ID_WIDTH-1:0]     cif_id,
   input  logic                    cif_hold,
   input  logic [DATA_WIDTH-1:0]   cif_rdata,
   input  logic                    cif_error
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_s;

   logic                    grant_wr_s;
   logic                    grant_rd_s;
   logic                    complete_s;
   logic                    resp_done_s;

   // prio_rd_r = 1 means the read channel wins the next contested grant
   logic                    prio_rd_r;

   logic                    cif_dv_r;
   logic                    cif_write_r;
   logic [ADDR_WIDTH-1:0]   cif_addr_r;
   logic [DATA_WIDTH-1:0]   cif_wdata_r;
   logic [STRB_WIDTH-1:0]   cif_wstrb_r;
   logic [USER_WIDTH-1:0]   cif_user_r;
   logic [ID_WIDTH-1:0]     cif_id_r;
   logic                    resp_error_r;
   logic [DATA_WIDTH-1:0]   resp_rdata_r;
   logic                    wr_resp_valid_r;
   logic                    rd_resp_valid_r;

   // State register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic, arbitration and completion/consume strobes
   always_comb begin
      state_s     = state_r;
      grant_wr_s  = 1'b0;
      grant_rd_s  = 1'b0;
      complete_s  = 1'b0;
      resp_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A lone valid always wins; prio_rd_r only breaks ties
            if (wr_req_valid && (!rd_req_valid || !prio_rd_r)) begin
               grant_wr_s = 1'b1;
            end else begin
               grant_wr_s = 1'b0;
            end
            if (rd_req_valid && !grant_wr_s) begin
               grant_rd_s = 1'b1;
            end else begin
               grant_rd_s = 1'b0;
            end
            if (grant_wr_s || grant_rd_s) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (!cif_hold) begin
               complete_s = 1'b1;
               state_s    = ST_RESP;
            end else begin
               state_s    = ST_REQ;
            end
         end
         ST_RESP: begin
            if (cif_write_r) begin
               resp_done_s = wr_resp_ready;
            end else begin
               resp_done_s = rd_resp_ready;
            end
            if (resp_done_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Request capture, priority update, completion capture and response valids
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         prio_rd_r       <= 1'b0;
         cif_dv_r        <= 1'b0;
         cif_write_r     <= 1'b0;
         cif_addr_r      <= {ADDR_WIDTH{1'b0}};
         cif_wdata_r     <= {DATA_WIDTH{1'b0}};
         cif_wstrb_r     <= {STRB_WIDTH{1'b0}};
         cif_user_r      <= {USER_WIDTH{1'b0}};
         cif_id_r        <= {ID_WIDTH{1'b0}};
         resp_error_r    <= 1'b0;
         resp_rdata_r    <= {DATA_WIDTH{1'b0}};
         wr_resp_valid_r <= 1'b0;
         rd_resp_valid_r <= 1'b0;
      end else begin
         if (grant_wr_s) begin
            prio_rd_r   <= 1'b1;
            cif_dv_r    <= 1'b1;
            cif_write_r <= 1'b1;
            cif_addr_r  <= wr_req_addr;
            cif_wdata_r <= wr_req_wdata;
            cif_wstrb_r <= wr_req_wstrb;
            cif_user_r  <= wr_req_user;
            cif_id_r    <= wr_req_id;
         end else if (grant_rd_s) begin
            prio_rd_r   <= 1'b0;
            cif_dv_r    <= 1'b1;
            cif_write_r <= 1'b0;
            cif_addr_r  <= rd_req_addr;
            cif_wdata_r <= {DATA_WIDTH{1'b0}};
            cif_wstrb_r <= {STRB_WIDTH{1'b0}};
            cif_user_r  <= rd_req_user;
            cif_id_r    <= rd_req_id;
         end else if (complete_s) begin
            cif_dv_r        <= 1'b0;
            resp_error_r    <= cif_error;
            // Read data register keeps its last read value across writes
            if (!cif_write_r) begin
               resp_rdata_r <= cif_rdata;
            end else begin
               resp_rdata_r <= resp_rdata_r;
            end
            wr_resp_valid_r <= cif_write_r;
            rd_resp_valid_r <= !cif_write_r;
         end else if (resp_done_s) begin
            wr_resp_valid_r <= 1'b0;
            rd_resp_valid_r <= 1'b0;
         end else begin
            cif_dv_r        <= cif_dv_r;
         end
      end
   end

   // Grant strobes are same-cycle by protocol; gated by reset so no grant is
   // advertised while the block is held in reset
   assign wr_req_ready  = grant_wr_s & rst_b;
   assign rd_req_ready  = grant_rd_s & rst_b;

   assign cif_dv        = cif_dv_r;
   assign cif_write     = cif_write_r;
   assign cif_addr      = cif_addr_r;
   assign cif_wdata     = cif_wdata_r;
   assign cif_wstrb     = cif_wstrb_r;
   assign cif_user      = cif_user_r;
   assign cif_id        = cif_id_r;

   assign wr_resp_valid = wr_resp_valid_r;
   assign wr_resp_error = resp_error_r;
   assign wr_resp_id    = cif_id_r;
   assign rd_resp_valid = rd_resp_valid_r;
   assign rd_resp_error = resp_error_r;
   assign rd_resp_rdata = resp_rdata_r;
   assign rd_resp_id    = cif_id_r;

endmodule

// File: tb/tb_mci_cif_req_arb.sv
// -----------------------------------------------------------------------------
// tb_mci_cif_req_arb
//
// Self-checking bench for mci_cif_req_arb. A transaction-level reference
// model (one outstanding transaction: granted -> at decoder -> response
// pending) predicts every output each cycle. Directed scenarios cover the
// basic write, held read, alternating arbitration, response backpressure,
// decoder error sampling and reset mid-request; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mci_cif_req_arb;

   logic        clk;
   logic        rst_b;
   logic        wr_req_valid, wr_req_ready;
   logic [31:0] wr_req_addr, wr_req_wdata, wr_req_user;
   logic [3:0]  wr_req_wstrb;
   logic [7:0]  wr_req_id;
   logic        rd_req_valid, rd_req_ready;
   logic [31:0] rd_req_addr, rd_req_user;
   logic [7:0]  rd_req_id;
   logic        wr_resp_valid, wr_resp_ready, wr_resp_error;
   logic [7:0]  wr_resp_id;
   logic        rd_resp_valid, rd_resp_ready, rd_resp_error;
   logic [31:0] rd_resp_rdata;
   logic [7:0]  rd_resp_id;
   logic        cif_dv, cif_write, cif_hold, cif_error;
   logic [31:0] cif_addr, cif_wdata, cif_user, cif_rdata;
   logic [3:0]  cif_wstrb;
   logic [7:0]  cif_id;

   int total;
   int bad;

   mci_cif_req_arb dut (
      .clk(clk), .rst_b(rst_b),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
      .wr_req_addr(wr_req_addr), .wr_req_wdata(wr_req_wdata),
      .wr_req_wstrb(wr_req_wstrb), .wr_req_user(wr_req_user), .wr_req_id(wr_req_id),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_addr(rd_req_addr), .rd_req_user(rd_req_user), .rd_req_id(rd_req_id),
      .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
      .wr_resp_error(wr_resp_error), .wr_resp_id(wr_resp_id),
      .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
      .rd_resp_error(rd_resp_error), .rd_resp_rdata(rd_resp_rdata), .rd_resp_id(rd_resp_id),
      .cif_dv(cif_dv), .cif_write(cif_write), .cif_addr(cif_addr),
      .cif_wdata(cif_wdata), .cif_wstrb(cif_wstrb), .cif_user(cif_user), .cif_id(cif_id),
      .cif_hold(cif_hold), .cif_rdata(cif_rdata), .cif_error(cif_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (transaction level) ----------------
   bit          m_busy;      // a transaction is outstanding
   bit          m_inresp;    // outstanding transaction has completed at decoder
   bit          m_last_wr;   // last grant went to write (read wins next tie)
   bit          m_wr;
   logic [31:0] m_addr, m_wdata, m_user, m_rdata;
   logic [3:0]  m_wstrb;
   logic [7:0]  m_id;
   bit          m_err;
   bit          g_wr, g_rd;  // expected grants this cycle
   bit          acc_wr, acc_rd; // observed grants (used only to drive stimulus)

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_inresp = 1'b0; m_last_wr = 1'b0; m_wr = 1'b0;
      m_rdata = 32'h0; m_err = 1'b0;
   endtask

   // Let inputs settle, then compare every output to the model's prediction
   task automatic settle_check();
      bit exp_dv, exp_wrv, exp_rdv;
      #1;
      if (!rst_b) model_reset();
      g_wr = rst_b && !m_busy && wr_req_valid && (!rd_req_valid || !m_last_wr);
      g_rd = rst_b && !m_busy && rd_req_valid && !g_wr;
      chk("wr_req_ready", 64'(wr_req_ready), 64'(g_wr));
      chk("rd_req_ready", 64'(rd_req_ready), 64'(g_rd));
      exp_dv  = m_busy && !m_inresp;
      exp_wrv = m_busy && m_inresp && m_wr;
      exp_rdv = m_busy && m_inresp && !m_wr;
      chk("cif_dv", 64'(cif_dv), 64'(exp_dv));
      if (exp_dv) begin
         chk("cif_write", 64'(cif_write), 64'(m_wr));
         chk("cif_addr",  64'(cif_addr),  64'(m_addr));
         chk("cif_wdata", 64'(cif_wdata), 64'(m_wr ? m_wdata : 32'h0));
         chk("cif_wstrb", 64'(cif_wstrb), 64'(m_wr ? m_wstrb : 4'h0));
         chk("cif_user",  64'(cif_user),  64'(m_user));
         chk("cif_id",    64'(cif_id),    64'(m_id));
      end
      chk("wr_resp_valid", 64'(wr_resp_valid), 64'(exp_wrv));
      chk("rd_resp_valid", 64'(rd_resp_valid), 64'(exp_rdv));
      if (exp_wrv) begin
         chk("wr_resp_id",    64'(wr_resp_id),    64'(m_id));
         chk("wr_resp_error", 64'(wr_resp_error), 64'(m_err));
      end
      if (exp_rdv) begin
         chk("rd_resp_id",    64'(rd_resp_id),    64'(m_id));
         chk("rd_resp_error", 64'(rd_resp_error), 64'(m_err));
      end
      chk("rd_resp_rdata", 64'(rd_resp_rdata), 64'(m_rdata));
      acc_wr = wr_req_ready;
      acc_rd = rd_req_ready;
   endtask

   // Advance the model across the coming clock edge, then step past it
   task automatic tick();
      if (!rst_b) begin
         model_reset();
      end else if (!m_busy) begin
         if (g_wr) begin
            m_busy = 1'b1; m_wr = 1'b1; m_last_wr = 1'b1;
            m_addr = wr_req_addr; m_wdata = wr_req_wdata; m_wstrb = wr_req_wstrb;
            m_user = wr_req_user; m_id = wr_req_id;
         end else if (g_rd) begin
            m_busy = 1'b1; m_wr = 1'b0; m_last_wr = 1'b0;
            m_addr = rd_req_addr; m_user = rd_req_user; m_id = rd_req_id;
         end
      end else if (!m_inresp) begin
         if (!cif_hold) begin
            m_inresp = 1'b1;
            m_err = cif_error;
            if (!m_wr) m_rdata = cif_rdata;
         end
      end else if (m_wr ? wr_resp_ready : rd_resp_ready) begin
         m_busy = 1'b0; m_inresp = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle_check();
      tick();
   endtask

   task automatic drain();
      wr_req_valid = 1'b0; rd_req_valid = 1'b0; cif_hold = 1'b0;
      wr_resp_ready = 1'b1; rd_resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
   endtask

   task automatic rand_wr();
      wr_req_addr = $urandom; wr_req_wdata = $urandom; wr_req_user = $urandom;
      wr_req_wstrb = 4'($urandom); wr_req_id = 8'($urandom);
   endtask

   task automatic rand_rd();
      rd_req_addr = $urandom; rd_req_user = $urandom; rd_req_id = 8'($urandom);
   endtask

   string glog;
   int    gcnt;
   int    vcnt;

   initial begin
      total = 0; bad = 0;
      model_reset();
      rst_b = 1'b0;
      wr_req_valid = 1'b0; rd_req_valid = 1'b0; rand_wr(); rand_rd();
      wr_resp_ready = 1'b1; rd_resp_ready = 1'b1;
      cif_hold = 1'b0; cif_rdata = 32'h0; cif_error = 1'b0;
      @(posedge clk); #1;

      // Reset state
      settle_check();
      chk("rst_cif_addr",  64'(cif_addr),  64'h0);
      chk("rst_cif_id",    64'(cif_id),    64'h0);
      chk("rst_cif_write", 64'(cif_write), 64'h0);
      chk("rst_error",     64'(rd_resp_error), 64'h0);
      tick();
      rst_b = 1'b1;
      cyc();

      // Single write, zero hold
      wr_req_valid = 1'b1; wr_req_addr = 32'h0000_0040; wr_req_wdata = 32'hA5A5_A5A5;
      wr_req_wstrb = 4'hF; wr_req_id = 8'd3; wr_req_user = 32'h0000_0011;
      settle_check(); chk("t1_ready", 64'(wr_req_ready), 64'h1); tick();
      wr_req_valid = 1'b0;
      settle_check();
      chk("t1_dv", 64'(cif_dv), 64'h1); chk("t1_write", 64'(cif_write), 64'h1);
      chk("t1_addr", 64'(cif_addr), 64'h40); chk("t1_wdata", 64'(cif_wdata), 64'hA5A5_A5A5);
      tick();
      settle_check();
      chk("t1_wrv", 64'(wr_resp_valid), 64'h1); chk("t1_id", 64'(wr_resp_id), 64'h3);
      chk("t1_err", 64'(wr_resp_error), 64'h0); chk("t1_rdv", 64'(rd_resp_valid), 64'h0);
      tick();
      drain();

      // Read held three cycles
      rd_req_valid = 1'b1; rd_req_addr = 32'h00C0_0000; rd_req_id = 8'h21;
      cyc();
      rd_req_valid = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         cif_hold = (i < 3); cif_rdata = (i < 3) ? $urandom : 32'h1234_5678;
         settle_check();
         if (cif_dv) vcnt++;
         chk("t2_addr", 64'(cif_addr), 64'h00C0_0000); chk("t2_wdata", 64'(cif_wdata), 64'h0);
         tick();
      end
      cif_hold = 1'b0;
      chk("t2_dvcnt", 64'(vcnt), 64'd4);
      settle_check();
      chk("t2_rdv", 64'(rd_resp_valid), 64'h1); chk("t2_rdata", 64'(rd_resp_rdata), 64'h1234_5678);
      chk("t2_err", 64'(rd_resp_error), 64'h0);
      tick();
      drain();

      // Both valid continuously: grants must alternate W,R,W,R
      glog = ""; gcnt = 0;
      rand_wr(); rand_rd(); wr_req_valid = 1'b1; rd_req_valid = 1'b1;
      for (int i = 0; i < 40 && gcnt < 4; i++) begin
         settle_check();
         if (acc_wr) begin glog = {glog, "W"}; gcnt++; end
         if (acc_rd) begin glog = {glog, "R"}; gcnt++; end
         tick();
         if (acc_wr) rand_wr();
         if (acc_rd) rand_rd();
      end
      chk("t3_gcnt", 64'(gcnt), 64'd4);
      chk("t3_order", 64'(glog == "WRWR"), 64'h1);
      drain();

      // Response backpressure with a read pending behind it
      rd_req_valid = 1'b1; rand_rd(); rd_resp_ready = 1'b0; cif_rdata = 32'hCAFE_0001;
      cyc();
      rand_rd();
      cyc();
      vcnt = 0;
      for (int i = 0; i < 6; i++) begin
         rd_resp_ready = (i == 5);
         cif_rdata = $urandom;
         settle_check();
         if (rd_resp_valid && rd_resp_rdata == 32'hCAFE_0001) vcnt++;
         chk("t4_rdready", 64'(rd_req_ready), 64'h0);
         tick();
      end
      chk("t4_validcnt", 64'(vcnt), 64'd6);
      settle_check(); chk("t4_regrant", 64'(rd_req_ready), 64'h1); tick();
      rd_req_valid = 1'b0;
      drain();

      // Decoder miss, then error pulsed only while held
      rd_req_valid = 1'b1; rd_req_addr = 32'h00F0_0000; rd_req_id = 8'h5A;
      cyc();
      rd_req_valid = 1'b0; cif_error = 1'b1;
      cyc();
      cif_error = 1'b0;
      settle_check();
      chk("t5_err", 64'(rd_resp_error), 64'h1); chk("t5_id", 64'(rd_resp_id), 64'h5A);
      tick();
      rd_req_valid = 1'b1; rd_req_id = 8'h5B;
      cyc();
      rd_req_valid = 1'b0; cif_hold = 1'b1; cif_error = 1'b1;
      cyc();
      cif_hold = 1'b0; cif_error = 1'b0;
      cyc();
      settle_check(); chk("t5_err2", 64'(rd_resp_error), 64'h0); tick();
      drain();

      // Reset while a write is held at the decoder
      wr_req_valid = 1'b1; rand_wr(); cif_hold = 1'b1;
      cyc();
      wr_req_valid = 1'b0;
      cyc();
      rst_b = 1'b0; wr_req_valid = 1'b1; rd_req_valid = 1'b1; rand_wr(); rand_rd();
      settle_check();
      chk("t6_dv", 64'(cif_dv), 64'h0); chk("t6_addr", 64'(cif_addr), 64'h0);
      chk("t6_wrready", 64'(wr_req_ready), 64'h0); chk("t6_rdready", 64'(rd_req_ready), 64'h0);
      tick();
      rst_b = 1'b1; cif_hold = 1'b0;
      settle_check();
      chk("t6_wfirst", 64'(wr_req_ready), 64'h1); chk("t6_rwait", 64'(rd_req_ready), 64'h0);
      tick();
      wr_req_valid = 1'b0; rd_req_valid = 1'b0;
      drain();

      // Randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         if (acc_wr || !wr_req_valid) begin
            wr_req_valid = ($urandom_range(0, 2) != 0); rand_wr();
         end
         if (acc_rd || !rd_req_valid) begin
            rd_req_valid = ($urandom_range(0, 2) != 0); rand_rd();
         end
         cif_hold      = ($urandom_range(0, 2) == 0);
         cif_rdata     = $urandom;
         cif_error     = ($urandom_range(0, 3) == 0);
         wr_resp_ready = ($urandom_range(0, 2) != 0);
         rd_resp_ready = ($urandom_range(0, 2) != 0);
         rst_b         = ($urandom_range(0, 399) != 0);
         cyc();
      end
      rst_b = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mci_cif_req_arb.md
# mci_cif_req_arb

Single-outstanding request arbiter sitting directly upstream of the MCI AXI subordinate address decoder. It takes already-assembled write requests (AW+W merged) and read requests (AR) from the AXI subordinate front end and serializes them onto one cif-style request channel (dv/hold/rdata/error) that feeds the decoder. It captures the decoder's completion and returns it to the originating channel. Arbitration between reads and writes is round-robin.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width
- USER_WIDTH, 32, AXI user width
- ID_WIDTH, 8, AXI transaction ID width

Ports:
- clk  in  1  clock
- rst_b  in  1  reset; one clock, reset is asynchronous and active-low
- wr_req_valid  in  1  write request pending
- wr_req_ready  out  1  write request accepted this cycle
- wr_req_addr / wr_req_wdata / wr_req_wstrb / wr_req_user / wr_req_id  in  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8 / USER_WIDTH / ID_WIDTH  write payload
- rd_req_valid  in  1  read request pending
- rd_req_ready  out  1  read request accepted this cycle
- rd_req_addr / rd_req_user / rd_req_id  in  ADDR_WIDTH / USER_WIDTH / ID_WIDTH  read payload
- wr_resp_valid  out  1  write completion available
- wr_resp_ready  in  1  write completion consumed
- wr_resp_error / wr_resp_id  out  1 / ID_WIDTH  write completion status and ID
- rd_resp_valid  out  1  read completion available
- rd_resp_ready  in  1  read completion consumed
- rd_resp_error / rd_resp_rdata / rd_resp_id  out  1 / DATA_WIDTH / ID_WIDTH  read completion
- cif_dv  out  1  request valid to decoder
- cif_write  out  1  1 = write, 0 = read
- cif_addr / cif_wdata / cif_wstrb / cif_user / cif_id  out  widths as above  request payload to decoder
- cif_hold  in  1  decoder/target stalls the current request
- cif_rdata  in  DATA_WIDTH  read data from decoder
- cif_error  in  1  decoder error (target error or address miss)

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if either valid is high, pick a winner. If only one is valid, it wins. If both are valid, the winner is chosen by the priority flag `prio_rd`. `prio_rd` resets to 0, so writes win first after reset.
- On the winning pick, assert that channel's `*_req_ready` combinationally for exactly that cycle. Register the payload, `cif_write` and the ID, then go to REQ. If the winner was the read channel, set `prio_rd` to 0; if it was the write channel, set it to 1. The flag updates only on contested or uncontested grants, always pointing to the other channel.
- The `*_req_ready` outputs are 0 in every state except IDLE.
- REQ:
  - `cif_dv` = 1 and all cif payload outputs are held stable.
  - The request completes on the first cycle with `cif_hold` = 0. At completion, capture `cif_error` and `cif_rdata` into the response registers and go to RESP.
  - `cif_rdata` is captured only for reads; the read-data register is unchanged on writes.
  - While `cif_hold` = 1, stay in REQ indefinitely.
- RESP: assert `wr_resp_valid` or `rd_resp_valid` according to the registered direction. The response ID equals the request ID. Stay until the matching `*_resp_ready` = 1, then go to IDLE. The other response valid stays 0.
- `cif_wdata` and `cif_wstrb` are driven to 0 on read requests.
- Exactly one transaction is outstanding at any time. There is no pipelining across transactions.

## Timing
- Reset values: state IDLE, `prio_rd` = 0, all outputs 0 (`*_ready`, `*_valid`, `cif_dv`, payloads, error, rdata).
- Accept in cycle N. `cif_dv` is high from N+1. With `cif_hold` = 0 at N+1, `*_resp_valid` is high at N+2.
- With response ready already high, IDLE is re-entered at N+3, so the next accept happens at N+3. Best-case throughput is one transaction per 3 cycles.
- Each cycle of `cif_hold` = 1 adds one cycle of latency.
- `*_resp_valid` must not drop before the matching ready is seen. Response data and error are stable while valid is high.
- A valid that rises while the FSM is busy waits. The upstream side must hold valid and payload until it sees its ready.
- Asynchronous reset in any state: on the next clock the FSM is IDLE, `cif_dv` = 0, any pending response is discarded, and `prio_rd` = 0. There is no partial completion.
- `cif_error` is sampled only on the completion cycle. Values while `cif_hold` = 1 are ignored.

## Test plan
- Single write, addr 0x0000_0040, wdata 0xA5A5_A5A5, wstrb 0xF, id 3, hold = 0 -> `wr_req_ready` at cycle 0, `cif_dv`/`cif_write` = 1 at cycle 1 with matching payload, `wr_resp_valid` at cycle 2 with id 3 and error 0, `rd_resp_valid` stays 0.
- Read, addr 0x00C0_0000, with `cif_hold` high 3 cycles and `cif_rdata` = 0x1234_5678 -> `cif_dv` held 4 cycles with a stable address, then `rd_resp_valid` with rdata 0x1234_5678, error 0, `cif_wdata` = 0.
- Write and read valid simultaneously and continuously, 4 transactions -> grant order W, R, W, R, with no two `cif_dv` intervals overlapping.
- Response backpressure: `rd_resp_ready` low 5 cycles -> `rd_resp_valid` and data stable for 6 cycles, `rd_req_ready` stays 0 despite a pending read, and the next grant comes 1 cycle after the ready handshake.
- Decoder miss: read addr 0x00F0_0000 with `cif_error` = 1 on the completion cycle -> `rd_resp_error` = 1, id preserved. Then `cif_error` pulsed only while hold = 1 on the next request -> error 0.
- rst_b asserted while in REQ with hold = 1 -> all outputs 0 immediately, IDLE after release. Both channels then valid -> write granted first.
